seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 154 +++++++++++++++
 tb/tb_seq_alu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: one accepted operation in, one
// registered result plus {n, z, c, v} flags out, each side valid/ready.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, s, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, a, b, s, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU. Add/sub/logic ops complete in one cycle. A shift by k
// takes k cycles, one bit per cycle. A multiply takes WIDTH cycles of
// shift-add. The result is held in DONE until the consumer takes it.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SHL, OP_MUL
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q;
  logic [2*WIDTH-1:0] acc_q;     // shl: value being shifted; mul: product
  logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q;  // multiplier, shifted right each step
  logic [CW-1:0]      cnt_q;     // steps still to run in BUSY
  logic [WIDTH-1:0]   out_q;
  logic [3:0]         flags_q;

  logic [SHW-1:0]     k;
  logic               go_busy;
  logic               last_step;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   imm_res;
  logic               imm_c, imm_v;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0]   step_res;
  logic               step_c;

  assign k         = bus.b[SHW-1:0];
  assign go_busy   = (bus.s == OP_MUL) || ((bus.s == OP_SHL) && (k != '0));
  assign last_step = (cnt_q == CNT_ONE);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: single-cycle ops skip BUSY; DONE waits for out_ready.
  always_comb begin
    // NOTE: default first, so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = go_busy ? BUSY : DONE;
      BUSY: if (last_step)    state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle results, taken straight from the request operands.
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = bus.a - bus.b;
    imm_res = bus.a;             // also the k = 0 shift result
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    unique case (op_e'(bus.s))
      OP_ADD: begin
        imm_res = sum[WIDTH-1:0];
        imm_c   = sum[WIDTH];
        imm_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        imm_res = diff;
        imm_c   = (bus.a < bus.b);
        imm_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: imm_res = bus.a & bus.b;
      OP_OR:  imm_res = bus.a | bus.b;
      OP_NOT: imm_res = ~bus.a;
      OP_XOR: imm_res = bus.a ^ bus.b;
      default: imm_res = bus.a;
    endcase
  end

  // One BUSY step; on the final step this is the delivered result.
  always_comb begin
    mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (op_q == OP_MUL) begin
      step_res = mul_sum[WIDTH-1:0];
      step_c   = |mul_sum[2*WIDTH-1:WIDTH];
    end else begin
      step_res = {acc_q[WIDTH-2:0], 1'b0};
      step_c   = acc_q[WIDTH-1];
    end
  end

  // Datapath: latch operands on accept, iterate in BUSY, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is reset, so an aborted operation leaves no residue.
    if (!rst_n) begin
      op_q     <= OP_ADD;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          op_q     <= op_e'(bus.s);
          mcand_q  <= {{WIDTH{1'b0}}, bus.a};
          mplier_q <= bus.b;
          if (bus.s == OP_MUL) begin
            acc_q <= '0;
            cnt_q <= CNT_MUL;
          end else begin
            acc_q <= {{WIDTH{1'b0}}, bus.a};
            cnt_q <= {1'b0, k};
          end
          if (!go_busy) begin
            out_q   <= imm_res;
            flags_q <= {imm_res[WIDTH-1], imm_res == '0, imm_c, imm_v};
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (op_q == OP_MUL) begin
            acc_q    <= mul_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end else begin
            acc_q <= acc_q << 1;
          end
          if (last_step) begin
            out_q   <= step_res;
            flags_q <= {step_res[WIDTH-1], step_res == '0, step_c, 1'b0};
          end
        end
        default: ;  // DONE holds out/flags until the consumer takes them
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH = 8): directed vectors, randomized
// operations with backpressure, and a reset abort in the middle of a multiply.
module tb_seq_alu;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model built from arithmetic on whole numbers: returns {flags, result}.
  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, r, sa, sr, k;
    logic c, v;
    logic [7:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 255); sr = sa + int'($signed(b)); v = (sr > 127) || (sr < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); sr = sa - int'($signed(b)); v = (sr > 127) || (sr < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ~ua;
      3'd5: r = ua ^ ub;
      3'd6: begin k = ub % W; r = ua << k; c = (k > 0) && (((r >> W) & 1) == 1); end
      default: begin r = ua * ub; c = (r > 255); end
    endcase
    res = r[7:0];
    return {res[7], res == 8'h00, c, v, res};
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [7:0] b);
    if (op == 3'd6) return int'(b) % W;
    if (op == 3'd7) return W;
    return 0;
  endfunction

  // Issue one operation (called #1 after a rising edge), check latency,
  // result and flags, hold out_ready low for `hold` cycles, then drain.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [11:0] exp;
    int lat, cycles;
    exp = model(op, a, b);
    lat = latency(op, b);
    check("ready_before", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.s = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    // scramble operands after accept; the in-flight result must not change
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.s = 3'($urandom);
    cycles = 0;
    while (!bus.out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check($sformatf("lat op%0d", op), 32'(cycles), 32'(lat));
    check($sformatf("out op%0d a=%0h b=%0h", op, a, b), 32'(bus.out), 32'(exp[7:0]));
    check($sformatf("flags op%0d a=%0h b=%0h", op, a, b), 32'(bus.flags), 32'(exp[11:8]));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.s = 3'($urandom);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_ready", 32'(bus.in_ready), 32'd0);
      check("hold_out", {20'd0, bus.flags, bus.out}, {20'd0, exp});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.s = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    rst_n = 1'b1;

    // directed vectors; the first is accepted on the first edge after release
    do_op(3'd0, 8'h7F, 8'h01, 0);
    do_op(3'd1, 8'h05, 8'h07, 1);
    do_op(3'd1, 8'h3C, 8'h3C, 0);
    do_op(3'd6, 8'h81, 8'h03, 0);
    do_op(3'd6, 8'h81, 8'h08, 0);
    do_op(3'd6, 8'hC1, 8'h07, 0);
    do_op(3'd7, 8'hC8, 8'h03, 0);
    do_op(3'd7, 8'h0F, 8'h11, 0);
    do_op(3'd0, 8'hFF, 8'h01, 0);
    do_op(3'd1, 8'h80, 8'h01, 0);
    do_op(3'd4, 8'hFF, 8'h00, 0);
    do_op(3'd7, 8'hFF, 8'hFF, 5);   // backpressure: 5 stalled cycles in DONE

    // reset in the third cycle of a multiply aborts it
    bus.in_valid = 1'b1;
    bus.s = 3'd7;
    bus.a = 8'hC8;
    bus.b = 8'h03;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out", {24'd0, bus.flags, bus.out[3:0]} | 32'(bus.out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    check("abort_out_zero", 32'(bus.out), 32'd0);
    do_op(3'd0, 8'h12, 8'h34, 0);

    // randomized operations with random backpressure
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
